// File: rtl/axis_conv_input_packer.sv
// axis_conv_input_packer: joins pixel and weight AXI-Streams into one packed conv-input beat
// through a 2-entry output buffer. Optional macro CONV_PACKER_LAST_CHECK_EN builds the
// sticky pixels/weights tlast mismatch detector.
module axis_conv_input_packer #(
    parameter int UNITS               = 8,
    parameter int CORES               = 4,
    parameter int KERNEL_W_MAX        = 3,
    parameter int WORD_WIDTH          = 8,
    parameter int TUSER_WIDTH_CONV_IN = 12,
    parameter int ZEROS_WIDTH         = 5,
    localparam int M_WIDTH = ZEROS_WIDTH + TUSER_WIDTH_CONV_IN + WORD_WIDTH*CORES*KERNEL_W_MAX + 2*WORD_WIDTH*UNITS
) (
    input  logic                                      aclk,
    input  logic                                      areset,
    input  logic                                      s_axis_pixels_tvalid,
    output logic                                      s_axis_pixels_tready,
    input  logic                                      s_axis_pixels_tlast,
    input  logic [WORD_WIDTH*UNITS-1:0]               s_axis_pixels_1_tdata,
    input  logic [WORD_WIDTH*UNITS-1:0]               s_axis_pixels_2_tdata,
    input  logic                                      s_axis_weights_tvalid,
    output logic                                      s_axis_weights_tready,
    input  logic                                      s_axis_weights_tlast,
    input  logic [WORD_WIDTH*CORES*KERNEL_W_MAX-1:0]  s_axis_weights_tdata,
    input  logic [TUSER_WIDTH_CONV_IN-1:0]            s_axis_weights_tuser,
    output logic                                      m_axis_tvalid,
    input  logic                                      m_axis_tready,
    output logic                                      m_axis_tlast,
    output logic [M_WIDTH-1:0]                        m_axis_tdata,
    output logic                                      last_mismatch
);
    logic [1:0]       r_count;
    logic [M_WIDTH:0] r_ent0;
    logic [M_WIDTH:0] r_ent1;
    logic             w_space;
    logic             w_fire;
    logic             w_pop;
    logic [M_WIDTH:0] w_beat;
    logic             w_wr0;
    logic             w_wr1;
    logic             w_shift;

    assign w_space = (r_count < 2'd2);
    assign s_axis_pixels_tready  = s_axis_weights_tvalid & w_space;
    assign s_axis_weights_tready = s_axis_pixels_tvalid & w_space;
    assign w_fire = s_axis_pixels_tvalid & s_axis_weights_tvalid & w_space;
    assign w_pop  = m_axis_tvalid & m_axis_tready;
    assign w_beat = {s_axis_weights_tlast, {ZEROS_WIDTH{1'b0}}, s_axis_weights_tuser,
                     s_axis_weights_tdata, s_axis_pixels_2_tdata, s_axis_pixels_1_tdata};
    // New beat lands at the head when the buffer is (or is about to be) empty, else behind it.
    assign w_wr0   = w_fire & ((r_count == 2'd0) | ((r_count == 2'd1) & w_pop));
    assign w_wr1   = w_fire & (r_count == 2'd1) & !w_pop;
    assign w_shift = w_pop & (r_count == 2'd2);

    assign m_axis_tvalid = (r_count != 2'd0);
    assign m_axis_tlast  = r_ent0[M_WIDTH];
    assign m_axis_tdata  = r_ent0[M_WIDTH-1:0];

    // Occupancy: +1 on accept, -1 on drain, unchanged when both happen together.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset)
            r_count <= 2'd0;
        else
            r_count <= r_count + {1'b0, w_fire} - {1'b0, w_pop};
    end

    // Head entry: loaded with a new beat or shifted up from the second entry.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset)
            r_ent0 <= '0;
        else if (w_wr0)
            r_ent0 <= w_beat;
        else if (w_shift)
            r_ent0 <= r_ent1;
    end

    // Second entry: only written when the head is occupied and stays occupied.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset)
            r_ent1 <= '0;
        else if (w_wr1)
            r_ent1 <= w_beat;
    end

`ifdef CONV_PACKER_LAST_CHECK_EN
    logic r_last_mismatch;

    // Sticky flag raised when the two streams disagree on packet end for an accepted beat.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset)
            r_last_mismatch <= 1'b0;
        else if (w_fire & (s_axis_pixels_tlast != s_axis_weights_tlast))
            r_last_mismatch <= 1'b1;
    end

    assign last_mismatch = r_last_mismatch;
`else
    logic w_unused;

    assign w_unused      = s_axis_pixels_tlast;
    assign last_mismatch = 1'b0;
`endif
endmodule

// File: doc/axis_conv_input_packer.md
# axis_conv_input_packer

Transmit-side counterpart of the conv engine input splitter. It joins an independent pixel AXI-Stream and weights AXI-Stream into the single packed conv-input beat, laid out as {zeros, tuser, weights, pixels_2, pixels_1}. It sits between the image/weights pipelines and the conv engine input, so both producers run decoupled from engine back-pressure. A 2-entry output buffer keeps input ready independent of `m_axis_tready` while sustaining one beat per clock.

## Interface

Parameters:

- `UNITS`, default 8: pixel words per pixel half.
- `CORES`, default 4: weight cores.
- `KERNEL_W_MAX`, default 3: weight words per core.
- `WORD_WIDTH`, default 8: bits per word.
- `TUSER_WIDTH_CONV_IN`, default 12: conv tuser width.
- `ZEROS_WIDTH`, default 5: zero pad at the MSBs.
- Derived `M_WIDTH` = ZEROS_WIDTH + TUSER_WIDTH_CONV_IN + WORD_WIDTH·CORES·KERNEL_W_MAX + 2·WORD_WIDTH·UNITS. This is 241 at the defaults.

Ports:

- `aclk`, in, 1: clock. All logic is on the rising edge.
- `areset`, in, 1: asynchronous, active-high reset.
- `s_axis_pixels_tvalid`, in, 1; `s_axis_pixels_tready`, out, 1; `s_axis_pixels_tlast`, in, 1: pixel stream handshake and packet end.
- `s_axis_pixels_1_tdata`, in, WORD_WIDTH·UNITS; `s_axis_pixels_2_tdata`, in, WORD_WIDTH·UNITS: the two pixel halves.
- `s_axis_weights_tvalid`, in, 1; `s_axis_weights_tready`, out, 1; `s_axis_weights_tlast`, in, 1: weights stream handshake and packet end.
- `s_axis_weights_tdata`, in, WORD_WIDTH·CORES·KERNEL_W_MAX: weights payload.
- `s_axis_weights_tuser`, in, TUSER_WIDTH_CONV_IN: conv tuser, carried with the weights.
- `m_axis_tvalid`, out, 1; `m_axis_tready`, in, 1; `m_axis_tlast`, out, 1: packed output handshake and packet end.
- `m_axis_tdata`, out, M_WIDTH: packed beat.
- `last_mismatch`, out, 1: sticky protocol-error flag.

## Operation

- **Join.** A beat is accepted (`fire`) when both inputs are valid and `count < 2`.
  - `s_axis_pixels_tready` = `s_axis_weights_tvalid` & (`count < 2`).
  - `s_axis_weights_tready` = `s_axis_pixels_tvalid` & (`count < 2`).
  - Neither ready may depend on `m_axis_tready`. Neither input is consumed without the other.
- **Packing.** Packed beat = {ZEROS_WIDTH'b0, weights_tuser, weights_tdata, pixels_2_tdata, pixels_1_tdata}, with pixels_1 at the LSBs. The pad is always zero.
- **tlast.** `m_axis_tlast` carries `s_axis_weights_tlast` of the same beat.
- **Buffer.** Two-entry FIFO of {tlast, tdata}, holding `count` ∈ {0, 1, 2}. The head entry drives `m_axis_*`. `m_axis_tvalid` = (`count != 0`).
- **Count update:**
  - `fire` with no `pop`: count+1.
  - `pop` with no `fire`: count−1.
  - `fire` and `pop` together: count unchanged, the head shifts and the new beat enters behind it.
  - `pop` = `m_axis_tvalid` & `m_axis_tready`.
- **Full** (`count == 2`): both input readys are 0. The entries hold stable until popped.
- **Empty** (`count == 0`): a `fire` beat appears on `m_axis` the next cycle. There is no combinational pass-through.
- **Reset** (asserted at any time, including mid-packet or full):
  - `count` = 0 and `m_axis_tvalid` = 0.
  - `m_axis_tdata` = 0 and `m_axis_tlast` = 0.
  - `last_mismatch` = 0.
  - Buffered beats are discarded.

## Timing

- Latency is 1 cycle, from the input `fire` edge to `m_axis_tvalid`.
- Throughput is 1 beat per cycle under continuous `m_axis_tready`.
- `m_axis_tdata` and `m_axis_tlast` come from registers and stay stable while `m_axis_tvalid` & !`m_axis_tready`.
- Input readys are combinational from the other stream's tvalid and the registered `count` only.

## Configuration

- `CONV_PACKER_LAST_CHECK_EN` **defined:**
  - On any `fire` where `s_axis_pixels_tlast` != `s_axis_weights_tlast`, `last_mismatch` sets 1 cycle later.
  - It stays set until `areset`.
  - Data flow is unaffected.
- **Not defined:** `last_mismatch` is tied to 0 and no compare logic is built.

## Test plan

- **Single beat:** reset, then pixels_1=0x01…, pixels_2=0x02…, weights=0xAA…, tuser=0x5A5, tready=1.
  - Required: one beat 1 cycle later.
  - Bits [63:0]=pixels_1, [127:64]=pixels_2, [223:128]=weights, [235:224]=0x5A5, [240:236]=0.
- **Stream join skew:** pixels valid 3 cycles before weights.
  - Required: `s_axis_pixels_tready`=0 until weights valid, then a single `fire`. No beat is duplicated or dropped.
- **Back-pressure:** 5 beats in, `m_axis_tready`=0.
  - Required: exactly 2 accepted and both readys low.
  - After release: 5 beats out in order at 1 per cycle, with data held stable while stalled.
- **Simultaneous push/pop:** with `count`=1, `fire` and `pop` in the same cycle.
  - Required: `count` stays 1, order is preserved, and throughput is 100% over 16 beats.
- **Reset mid-full:** `count`=2, assert `areset`.
  - Required: `m_axis_tvalid`=0, `m_axis_tdata`=0 and readys reflect count 0 immediately. The first post-reset beat appears after 1 cycle.
- **tlast check:** `fire` with pixels_tlast=1 and weights_tlast=0.
  - Required with `CONV_PACKER_LAST_CHECK_EN` defined: `last_mismatch`=1 the next cycle and sticky until reset.
  - Required without it: `last_mismatch` stays 0.
  - Required in both builds: `m_axis_tlast`=0.
